// File: rtl/timer_bus_pkg.sv
// Shared constants for the timer-counter register bus master: register map,
// bus widths and the master FSM state encoding.
package timer_bus_pkg;

   localparam int unsigned BUS_DW = 16;
   localparam int unsigned BUS_AW = 4;

   localparam logic [BUS_AW-1:0] ADDR_TCCR  = 4'h1;
   localparam logic [BUS_AW-1:0] ADDR_TCCR2 = 4'h2;
   localparam logic [BUS_AW-1:0] ADDR_TCNT  = 4'h3;
   localparam logic [BUS_AW-1:0] ADDR_OCR   = 4'h4;
   localparam logic [BUS_AW-1:0] ADDR_ICR   = 4'h5;
   localparam logic [BUS_AW-1:0] ADDR_TCST  = 4'h6;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      TURN   = 2'd2,
      RESP   = 2'd3
   } state_e;

endpackage

// File: rtl/bus_timeout_cnt.sv
// Counts ACCESS cycles and flags the cycle in which the wait for acknowledge
// has lasted TIMEOUT_CYC cycles.
module bus_timeout_cnt #(
   parameter int unsigned TIMEOUT_CYC = 16,
   parameter int unsigned TO_W        = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   logic [TO_W-1:0] cnt_q;

   // Cycle counter, cleared when a request is accepted.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i) begin
         cnt_q <= cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_q <= cnt_q;
      end
   end

   assign expire_o = en_i && (cnt_q == TO_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/timer_bus_master.sv
// Single-outstanding register bus initiator for the timer-counter peripheral.
// Optional ack timeout/abort path enabled by TIMER_BUS_MASTER_TIMEOUT_EN.
module timer_bus_master
   import timer_bus_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 16,
   parameter int unsigned TO_W        = 16
) (
   input  logic              i_sysclk,
   input  logic              i_sysrst,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_wr,
   input  logic [BUS_AW-1:0] i_req_addr,
   input  logic [BUS_DW-1:0] i_req_wdata,
   output logic              o_rsp_valid,
   input  logic              i_rsp_ready,
   output logic [BUS_DW-1:0] o_rsp_rdata,
   output logic              o_rsp_err,
   output logic              o_bus_select,
   output logic              o_bus_wr,
   output logic [BUS_AW-1:0] o_reg_addr,
   output logic [BUS_DW-1:0] o_bus_data,
   input  logic [BUS_DW-1:0] i_bus_data,
   input  logic              i_bus_ack,
   output logic              o_busy
);

   if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535 ||
       (64'd1 << TO_W) <= 64'(TIMEOUT_CYC)) begin : g_bad_cfg
      $error("timer_bus_master: TIMEOUT_CYC/TO_W out of range");
   end

   state_e            state_q;
   logic              req_ready_q;
   logic              rsp_valid_q;
   logic              rsp_err_q;
   logic [BUS_DW-1:0] rsp_rdata_q;
   logic              sel_q;
   logic              wr_q;
   logic [BUS_AW-1:0] addr_q;
   logic [BUS_DW-1:0] wdata_q;
   logic              busy_q;
   logic              timeout_hit;

`ifdef TIMER_BUS_MASTER_TIMEOUT_EN
   logic cnt_clr;
   logic cnt_en;

   assign cnt_clr = (state_q == IDLE) && i_req_valid && req_ready_q;
   assign cnt_en  = (state_q == ACCESS);

   bus_timeout_cnt #(
      .TIMEOUT_CYC(TIMEOUT_CYC),
      .TO_W       (TO_W)
   ) u_timeout_cnt (
      .clk_i   (i_sysclk),
      .rst_i   (i_sysrst),
      .clr_i   (cnt_clr),
      .en_i    (cnt_en),
      .expire_o(timeout_hit)
   );
`else
   assign timeout_hit = 1'b0;
`endif

   // Transaction FSM; every output is a register updated here.
   always_ff @(posedge i_sysclk or posedge i_sysrst) begin
      if (i_sysrst) begin
         state_q     <= IDLE;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         sel_q       <= 1'b0;
         wr_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (i_req_valid && req_ready_q) begin
                  sel_q       <= 1'b1;
                  wr_q        <= i_req_wr;
                  addr_q      <= i_req_addr;
                  wdata_q     <= i_req_wdata;
                  req_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  state_q     <= ACCESS;
               end else begin
                  req_ready_q <= 1'b1;
               end
            end
            ACCESS: begin
               // Ack has priority over a timeout expiring in the same cycle.
               if (i_bus_ack || timeout_hit) begin
                  rsp_rdata_q <= (i_bus_ack && !wr_q) ? i_bus_data : '0;
                  rsp_err_q   <= !i_bus_ack;
                  sel_q       <= 1'b0;
                  wr_q        <= 1'b0;
                  addr_q      <= '0;
                  wdata_q     <= '0;
                  state_q     <= TURN;
               end else begin
                  state_q     <= ACCESS;
               end
            end
            TURN: begin
               // The peripheral's trailing ack is deliberately not looked at here.
               rsp_valid_q <= 1'b1;
               state_q     <= RESP;
            end
            RESP: begin
               if (i_rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  rsp_rdata_q <= '0;
                  rsp_err_q   <= 1'b0;
                  busy_q      <= 1'b0;
                  req_ready_q <= 1'b1;
                  state_q     <= IDLE;
               end else begin
                  state_q     <= RESP;
               end
            end
            default: begin
               state_q     <= IDLE;
               req_ready_q <= 1'b0;
               rsp_valid_q <= 1'b0;
               sel_q       <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign o_req_ready  = req_ready_q;
   assign o_rsp_valid  = rsp_valid_q;
   assign o_rsp_rdata  = rsp_rdata_q;
   assign o_rsp_err    = rsp_err_q;
   assign o_bus_select = sel_q;
   assign o_bus_wr     = wr_q;
   assign o_reg_addr   = addr_q;
   assign o_bus_data   = wdata_q;
   assign o_busy       = busy_q;

endmodule
